// File: rtl/prime_pkg.sv
// Shared types and helpers for the sequential trial-division prime checker.
package prime_pkg;

  localparam int unsigned PRIME_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_DIV   = 2'd2,
    ST_DONE  = 2'd3
  } prime_state_t;

  // d*d > n evaluated at double width so the square never overflows (operands up to 32 bits)
  function automatic logic sq_gt(input logic [31:0] d, input logic [31:0] n);
    logic [63:0] sq;
    sq = 64'(d) * 64'(d);
    return sq > 64'(n);
  endfunction

endpackage

// File: rtl/prime_rem_unit.sv
// Restoring shift-subtract remainder: rem = n mod d, rem_done pulses WIDTH+1 cycles after rem_start.
module prime_rem_unit
  import prime_pkg::*;
#(
  parameter int unsigned WIDTH = PRIME_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rem_start,
  input  logic [WIDTH-1:0] n,
  input  logic [WIDTH-1:0] d,
  output logic             rem_done,
  output logic [WIDTH-1:0] rem
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_rem;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH:0]   w_trial;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nx;

  // One restoring step: bring in the next dividend bit, subtract when it fits
  always_comb begin
    w_trial  = {r_rem, r_dvd[WIDTH-1]};
    w_ge     = (w_trial >= {1'b0, r_div});
    w_rem_nx = w_trial[WIDTH-1:0];
    if (w_ge) begin
      w_rem_nx = WIDTH'(w_trial - {1'b0, r_div});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dvd  <= '0;
      r_div  <= '0;
      r_rem  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (rem_start) begin
        r_dvd  <= n;
        r_div  <= d;
        r_rem  <= '0;
        r_cnt  <= CW'(WIDTH);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_dvd <= r_dvd << 1;
        r_rem <= w_rem_nx;
        r_cnt <= r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign rem_done = r_done;
  assign rem      = r_rem;

endmodule

// File: rtl/prime_checker_seq.sv
// Multi-cycle primality tester by trial division with valid/ready on both sides.
// Build option PRIME_ODD_SKIP_EN: after d=2 only odd divisors are tried (same results, lower latency).
module prime_checker_seq
  import prime_pkg::*;
#(
  parameter int unsigned WIDTH = PRIME_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_n,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_prime,
  output logic [WIDTH-1:0] out_factor
);

  prime_state_t     r_state,  w_state_nx;
  logic [WIDTH-1:0] r_n,      w_n_nx;
  logic [WIDTH-1:0] r_d,      w_d_nx;
  logic             r_in_ready;
  logic             r_out_valid,  w_out_valid_nx;
  logic             r_out_prime,  w_out_prime_nx;
  logic [WIDTH-1:0] r_out_factor, w_out_factor_nx;

  logic             w_rem_start;
  logic             w_rem_done;
  logic [WIDTH-1:0] w_rem;
  logic             w_sq_gt;
  logic [WIDTH-1:0] w_d_adv;

  prime_rem_unit #(.WIDTH(WIDTH)) u_rem (
    .clk       (clk),
    .rst_n     (rst_n),
    .rem_start (w_rem_start),
    .n         (r_n),
    .d         (r_d),
    .rem_done  (w_rem_done),
    .rem       (w_rem)
  );

  assign w_sq_gt = sq_gt(32'(r_d), 32'(r_n));

`ifdef PRIME_ODD_SKIP_EN
  assign w_d_adv = (r_d == WIDTH'(2)) ? WIDTH'(3) : r_d + WIDTH'(2);
`else
  assign w_d_adv = r_d + WIDTH'(1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_n          <= '0;
      r_d          <= '0;
      r_in_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_prime  <= 1'b0;
      r_out_factor <= '0;
    end else begin
      r_state      <= w_state_nx;
      r_n          <= w_n_nx;
      r_d          <= w_d_nx;
      r_in_ready   <= (w_state_nx == ST_IDLE);
      r_out_valid  <= w_out_valid_nx;
      r_out_prime  <= w_out_prime_nx;
      r_out_factor <= w_out_factor_nx;
    end
  end

  // Next-state and registered-output decode
  always_comb begin
    w_state_nx      = r_state;
    w_n_nx          = r_n;
    w_d_nx          = r_d;
    w_out_valid_nx  = r_out_valid;
    w_out_prime_nx  = r_out_prime;
    w_out_factor_nx = r_out_factor;
    w_rem_start     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (in_valid && r_in_ready) begin
          w_n_nx     = in_n;
          w_d_nx     = WIDTH'(2);
          w_state_nx = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (r_n < WIDTH'(2)) begin
          w_out_valid_nx  = 1'b1;
          w_out_prime_nx  = 1'b0;
          w_out_factor_nx = '0;
          w_state_nx      = ST_DONE;
        end else if (w_sq_gt) begin
          w_out_valid_nx  = 1'b1;
          w_out_prime_nx  = 1'b1;
          w_out_factor_nx = '0;
          w_state_nx      = ST_DONE;
        end else begin
          w_rem_start = 1'b1;
          w_state_nx  = ST_DIV;
        end
      end
      ST_DIV: begin
        if (w_rem_done) begin
          if (w_rem == '0) begin
            w_out_valid_nx  = 1'b1;
            w_out_prime_nx  = 1'b0;
            w_out_factor_nx = r_d;
            w_state_nx      = ST_DONE;
          end else begin
            w_d_nx     = w_d_adv;
            w_state_nx = ST_CHECK;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_out_valid_nx = 1'b0;
          w_state_nx     = ST_IDLE;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_prime  = r_out_prime;
  assign out_factor = r_out_factor;

endmodule

// File: tb/tb_prime_checker_seq.sv
// Self-checking bench for prime_checker_seq (WIDTH=8), honours PRIME_ODD_SKIP_EN for latency expectations.
module tb_prime_checker_seq;

  localparam int unsigned W = 8;
  localparam int TMO = 4000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_n = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         out_prime;
  logic [W-1:0] out_factor;

  prime_checker_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_n       (in_n),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_prime  (out_prime),
    .out_factor (out_factor)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n;
    int prime;
    int factor;
    int lat;
    int acc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   seen = 0;
  bit   ready_expected = 0;
  int   last_prime = -1;
  int   last_factor = -1;
  int   last_lat = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic int next_d(input int d);
`ifdef PRIME_ODD_SKIP_EN
    return (d == 2) ? 3 : d + 2;
`else
    return d + 1;
`endif
  endfunction

  // Reference: smallest factor by plain trial division; latency from trial count
  function automatic exp_t model(input int n);
    exp_t e;
    int d;
    int k;
    bit found;
    e.n = n; e.prime = 0; e.factor = 0; e.acc = 0;
    d = 2; k = 0; found = 0;
    if (n < 2) begin
      e.lat = 2;
    end else begin
      while (!found && d * d <= n) begin
        k++;
        if (n % d == 0) begin
          found = 1;
          e.factor = d;
        end else begin
          d = next_d(d);
        end
      end
      e.prime = found ? 0 : 1;
      e.lat = (found ? 1 : 2) + k * (W + 2);
    end
    return e;
  endfunction

  // Compare process: every cycle a result is presented it must match the head expectation
  always @(negedge clk) begin
    if (rst_n) begin
      if (ready_expected) begin
        chk("in_ready_after_consume", int'(in_ready), 1);
        ready_expected = 0;
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", 1, 0);
        end else begin
          chk($sformatf("prime_n%0d", exp_q[0].n), int'(out_prime), exp_q[0].prime);
          chk($sformatf("factor_n%0d", exp_q[0].n), int'(out_factor), exp_q[0].factor);
          chk("in_ready_low_while_valid", int'(in_ready), 0);
          if (!seen) begin
            seen = 1;
            last_lat = cyc - exp_q[0].acc;
            chk($sformatf("latency_n%0d", exp_q[0].n), last_lat, exp_q[0].lat);
          end
          if (out_ready) begin
            last_prime  = int'(out_prime);
            last_factor = int'(out_factor);
            void'(exp_q.pop_front());
            seen = 0;
            ready_expected = 1;
          end
        end
      end
    end
  end

  task automatic send(input int n);
    exp_t e;
    int t;
    t = 0;
    @(posedge clk); #1;
    in_n = W'(n);
    in_valid = 1'b1;
    while (!in_ready && t < TMO) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= TMO) begin
      chk("timeout_in_ready", 0, 1);
    end else begin
      e = model(n);
      e.acc = cyc;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < TMO) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      chk("timeout_result", 0, 1);
      exp_q.delete();
      seen = 0;
    end
  endtask

  task automatic run(input int n);
    send(n);
    drain();
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_prime", int'(out_prime), 0);
    chk("rst_out_factor", int'(out_factor), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("in_ready_before_first_edge", int'(in_ready), 0);
    @(negedge clk);
    chk("in_ready_after_first_edge", int'(in_ready), 1);

    // Small operands back to back
    for (int n = 0; n < 4; n++) run(n);
    chk("lit_n3_prime", last_prime, 1);
    chk("lit_n3_lat", last_lat, 2);

    // Composites with hand-computed factors
    run(91);
    chk("lit_n91_prime", last_prime, 0);
    chk("lit_n91_factor", last_factor, 7);
    run(255);
    chk("lit_n255_factor", last_factor, 3);
    run(4);
    chk("lit_n4_factor", last_factor, 2);
    chk("lit_n4_lat", last_lat, 11);

    // Largest prime below 256
    run(251);
    chk("lit_n251_prime", last_prime, 1);
    chk("lit_n251_factor", last_factor, 0);
`ifdef PRIME_ODD_SKIP_EN
    chk("lit_n251_lat", last_lat, 82);
`else
    chk("lit_n251_lat", last_lat, 142);
`endif

    // Backpressure: result held for 10 cycles
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(97);
    begin
      int t;
      t = 0;
      while (!out_valid && t < TMO) begin
        @(negedge clk);
        t++;
      end
      chk("bp_valid_seen", int'(out_valid), 1);
    end
    repeat (10) @(negedge clk);
    chk("bp_still_valid", int'(out_valid), 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();
    chk("lit_n97_prime", last_prime, 1);

    // Reset in the middle of a division
    send(251);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    seen = 0;
    ready_expected = 0;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 0);
    chk("midrst_out_prime", int'(out_prime), 0);
    chk("midrst_out_factor", int'(out_factor), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready_after", int'(in_ready), 1);
    chk("midrst_no_result", int'(out_valid), 0);
    run(5);
    chk("lit_n5_prime", last_prime, 1);

    // Full operand range against the model
    for (int n = 0; n < 256; n++) run(n);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
